// File: rtl/wb_ppm_rx_pkg.sv
// Shared register map, status/control bit positions and FSM encoding for the PPM receiver.
package wb_ppm_rx_pkg;

    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_CTRL   = 4'h1;
    localparam logic [3:0] REG_FRAMES = 4'h2;
    localparam logic [3:0] REG_CH0    = 4'h4;

    localparam int ST_VALID   = 0;
    localparam int ST_LOST    = 1;
    localparam int ST_IRQ     = 2;
    localparam int ST_BAD     = 3;
    localparam int ST_OVF     = 4;
    localparam int ST_CNT_LSB = 8;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } ppm_state_t;

    function automatic logic [3:0] sat_min(input logic [3:0] a, input logic [3:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ppm_edge_timer.sv
// PPM front end: 2-FF synchronizer, rise pulse, 1 us prescaler and a saturating
// interval counter that restarts on every rising edge.
module ppm_edge_timer #(
    parameter int CLK_DIV    = 50,
    parameter int TIMEOUT_US = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ppm_in,
    output logic        rise,
    output logic [15:0] interval,
    output logic        timeout
);

    localparam logic [31:0] PRE_MAX = (CLK_DIV > 1) ? 32'(CLK_DIV - 1) : 32'd0;

    logic [2:0]  sync_q;
    logic        rise_q;
    logic [31:0] pre_cnt;
    logic        us_tick;
    logic [15:0] us_cnt;

    assign us_tick = (pre_cnt == PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            rise_q  <= 1'b0;
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else begin
            // [0],[1] are the synchronizer; [2] is the delayed copy for edge detect
            sync_q  <= {sync_q[1:0], ppm_in};
            rise_q  <= sync_q[1] & ~sync_q[2];
            pre_cnt <= us_tick ? 32'd0 : pre_cnt + 32'd1;
            if (!en || rise_q)
                us_cnt <= '0;
            else if (us_tick && us_cnt != 16'hFFFF)
                us_cnt <= us_cnt + 16'd1;
        end
    end

    assign rise     = rise_q;
    assign interval = us_cnt;
    assign timeout  = en && ({16'd0, us_cnt} >= 32'(TIMEOUT_US));

endmodule

// File: rtl/wb_ppm_rx.sv
// Wishbone PPM receiver: frame FSM, live/shadow channel banks and register file.
// The shadow bank is only ever replaced whole, so CPU reads see one coherent frame.
module wb_ppm_rx
    import wb_ppm_rx_pkg::*;
#(
    parameter int clk_freq   = 50000000,
    parameter int NUM_CH     = 8,
    parameter int SYNC_US    = 3000,
    parameter int MIN_US     = 500,
    parameter int TIMEOUT_US = 25000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    input  logic        ppm_in,
    output logic        intr
);

    localparam logic [15:0] SYNC_W  = 16'(SYNC_US);
    localparam logic [15:0] MIN_W   = 16'(MIN_US);
    localparam logic [3:0]  NUM_CH4 = 4'(NUM_CH);

    ppm_state_t state_q, state_d;

    logic                   rise, timeout;
    logic [15:0]            interval;
    logic                   ctrl_en, ctrl_irq_en;
    logic                   valid, lost, irq_pend, bad_frame, overflow;
    logic [3:0]             ch_count, ch_idx;
    logic [15:0]            frames;
    logic [NUM_CH-1:0][15:0] live, shadow;

    logic ev_commit, ev_store, ev_ovf, ev_bad, ev_lost, idx_clr, idx_inc;
    logic wb_acc, wr_en, rd_en, wr_status, wr_ctrl;
    logic [3:0]  reg_idx;
    logic [2:0]  w1c;
    logic [31:0] rd_data;
    logic        unused_bits;

    ppm_edge_timer #(
        .CLK_DIV    (clk_freq / 1000000),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_en),
        .ppm_in   (ppm_in),
        .rise     (rise),
        .interval (interval),
        .timeout  (timeout)
    );

    always_comb begin
        state_d   = state_q;
        ev_commit = 1'b0;
        ev_store  = 1'b0;
        ev_ovf    = 1'b0;
        ev_bad    = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        if (!ctrl_en) begin
            state_d = HUNT;
        end else if (rise) begin
            // A rise ends the silence, so it takes precedence over a coincident timeout
            case (state_q)
                HUNT: if (interval >= SYNC_W) begin
                    state_d = RUN;
                    idx_clr = 1'b1;
                end
                RUN: if (interval < MIN_W) begin
                    ev_bad  = 1'b1;
                    state_d = HUNT;
                end else if (interval >= SYNC_W) begin
                    idx_clr   = 1'b1;
                    ev_commit = (ch_idx != 4'd0);
                end else begin
                    idx_inc  = 1'b1;
                    ev_store = (ch_idx < NUM_CH4);
                    ev_ovf   = ~(ch_idx < NUM_CH4);
                end
                default: state_d = HUNT;
            endcase
        end else if (timeout) begin
            state_d = HUNT;
        end
    end

    assign ev_lost = timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= HUNT;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_idx    <= '0;
            ch_count  <= '0;
            frames    <= '0;
            valid     <= 1'b0;
            lost      <= 1'b0;
            irq_pend  <= 1'b0;
            bad_frame <= 1'b0;
            overflow  <= 1'b0;
            live      <= '0;
            shadow    <= '0;
        end else begin
            if (idx_clr)
                ch_idx <= '0;
            else if (idx_inc && ch_idx != 4'hF)
                ch_idx <= ch_idx + 4'd1;
            for (int n = 0; n < NUM_CH; n++)
                if (ev_store && ch_idx == 4'(n))
                    live[n] <= interval;
            if (ev_commit) begin
                shadow   <= live;
                ch_count <= sat_min(ch_idx, NUM_CH4);
                frames   <= frames + 16'd1;
            end
            if (!ctrl_en || ev_lost) valid <= 1'b0;
            else if (ev_commit)      valid <= 1'b1;
            if (ev_lost)             lost  <= 1'b1;
            else if (ev_commit)      lost  <= 1'b0;
            // Hardware set beats a same-cycle W1C clear
            irq_pend  <= (irq_pend  & ~w1c[0]) | ev_commit;
            bad_frame <= (bad_frame & ~w1c[1]) | ev_bad;
            overflow  <= (overflow  & ~w1c[2]) | ev_ovf;
        end
    end

    assign wb_acc    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr_en     = wb_acc & wb_we_i;
    assign rd_en     = wb_acc & ~wb_we_i;
    assign reg_idx   = wb_adr_i[5:2];
    assign wr_status = wr_en && (reg_idx == REG_STATUS);
    assign wr_ctrl   = wr_en && (reg_idx == REG_CTRL);
    assign w1c       = wr_status ? wb_dat_i[ST_OVF:ST_IRQ] : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en     <= wb_dat_i[CTRL_EN];
            ctrl_irq_en <= wb_dat_i[CTRL_IRQ_EN];
        end
    end

    // Only [5:2] is decoded, so channel words beyond index 11 are not addressable
    always_comb begin
        rd_data = '0;
        case (reg_idx)
            REG_STATUS: rd_data = {20'd0, ch_count, 3'd0, overflow, bad_frame, irq_pend, lost, valid};
            REG_CTRL:   rd_data = {30'd0, ctrl_irq_en, ctrl_en};
            REG_FRAMES: rd_data = {16'd0, frames};
            default: begin
                for (int n = 0; n < NUM_CH; n++)
                    if (int'(reg_idx) == int'(REG_CH0) + n)
                        rd_data = {16'd0, shadow[n]};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_acc;
            wb_dat_o <= rd_en ? rd_data : 32'd0;
        end
    end

    assign intr        = irq_pend & ctrl_irq_en;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:5]};

endmodule

// File: tb/tb_wb_ppm_rx.sv
// Directed bench for wb_ppm_rx with time constants scaled down 10x (2 MHz clock, 2 clk per us).
`timescale 1ns/1ps
module tb_wb_ppm_rx;

    localparam int SYNC = 300;
    localparam int GAP  = 320;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
    logic        ppm_in, intr;

    int errors = 0;
    int checks = 0;

    wb_ppm_rx #(
        .clk_freq   (2000000),
        .NUM_CH     (8),
        .SYNC_US    (SYNC),
        .MIN_US     (50),
        .TIMEOUT_US (2500)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_we_i  (wb_we_i),
        .wb_ack_o (wb_ack_o),
        .ppm_in   (ppm_in),
        .intr     (intr)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // One Wishbone access, entered and left on a negedge. ack_ok: ack seen on the
    // first cycle and gone on the next.
    task automatic wb_xfer(input logic we, input logic [3:0] idx, input logic [31:0] wdat,
                           output logic [31:0] rdat, output logic ack_ok);
        int n;
        wb_adr_i = {26'd0, idx, 2'b00};
        wb_we_i  = we;
        wb_dat_i = wdat;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_ack_o && n < 4);
        ack_ok   = wb_ack_o && (n == 1);
        rdat     = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk);
        if (wb_ack_o) ack_ok = 1'b0;
    endtask

    task automatic idle_us(input int us);
        ppm_in = 1'b0;
        repeat (2 * us) @(negedge clk);
    endtask

    // Rising edge, then the line stays quiet until `us` after that edge
    task automatic gap_us(input int us);
        ppm_in = 1'b1;
        repeat (20) @(negedge clk);
        ppm_in = 1'b0;
        repeat (2 * us - 20) @(negedge clk);
    endtask

    task automatic pulse();
        ppm_in = 1'b1;
        repeat (10) @(negedge clk);
        ppm_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Sync-length idle, one interval per channel, then a sync gap; the next rise closes the frame
    task automatic send_body(input int ws[16], input int n);
        idle_us(GAP);
        for (int i = 0; i < n; i++) gap_us(ws[i]);
        gap_us(GAP);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        ok;
        logic [3:0]  idxs[7];
        idxs = '{4'h0, 4'h1, 4'h2, 4'h4, 4'hB, 4'h3, 4'hF};
        checks++;
        if (intr !== 1'b0 || wb_ack_o !== 1'b0 || wb_dat_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: intr=%b ack=%b dat=%h, want 0 0 0", intr, wb_ack_o, wb_dat_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        foreach (idxs[i]) begin
            wb_xfer(1'b0, idxs[i], 32'd0, rd, ok);
            checks++;
            if (rd !== 32'd0 || ok !== 1'b1) begin
                errors++;
                $display("FAIL reset_read[%0h]: data=%h ack_ok=%b, want 0 and 1", idxs[i], rd, ok);
            end
        end
        wb_xfer(1'b1, 4'h2, 32'hFFFF_FFFF, rd, ok);
        wb_xfer(1'b1, 4'h3, 32'hFFFF_FFFF, rd, ok);
        wb_xfer(1'b0, 4'h2, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL frames_ro: got %h, want 0", rd);
        end
        checks++;
        if (intr !== 1'b0) begin
            errors++;
            $display("FAIL reset_intr: got %b, want 0", intr);
        end
    endtask

    task automatic test_frame();
        logic [31:0] rd;
        logic        ok;
        int          w[16];
        int          d;
        for (int i = 0; i < 16; i++) w[i] = 100 + 10 * i;
        wb_xfer(1'b1, 4'h1, 32'h3, rd, ok);
        wb_xfer(1'b0, 4'h1, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL ctrl_rw: got %h, want 3", rd);
        end
        send_body(w, 8);
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL status_before_end: got %h, want 0", rd);
        end
        pulse();
        for (int i = 0; i < 8; i++) begin
            wb_xfer(1'b0, 4'(4 + i), 32'd0, rd, ok);
            d = int'(rd[15:0]) - w[i];
            checks++;
            if (d < -1 || d > 1 || rd[31:16] !== 16'd0) begin
                errors++;
                $display("FAIL frame_ch%0d: got %0d, want %0d+-1", i, rd, w[i]);
            end
        end
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h805) begin
            errors++;
            $display("FAIL frame_status: got %h, want 805", rd);
        end
        wb_xfer(1'b0, 4'h2, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'd1 || intr !== 1'b1) begin
            errors++;
            $display("FAIL frame_count_intr: frames=%0d intr=%b, want 1 1", rd, intr);
        end
    endtask

    task automatic test_irq_clear();
        logic [31:0] rd;
        logic        ok;
        int          w[16];
        for (int i = 0; i < 16; i++) w[i] = 100 + 10 * i;
        wb_xfer(1'b1, 4'h0, 32'h4, rd, ok);
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (intr !== 1'b0 || rd !== 32'h801) begin
            errors++;
            $display("FAIL irq_w1c: intr=%b status=%h, want 0 801", intr, rd);
        end
        send_body(w, 8);
        // Closing edge: rise reaches the FSM on the 4th posedge, the same edge the write lands
        ppm_in = 1'b1;
        repeat (3) @(negedge clk);
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h4;
        wb_we_i  = 1'b1;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        @(negedge clk);
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (6) @(negedge clk);
        ppm_in = 1'b0;
        repeat (4) @(negedge clk);
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h805 || intr !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins: status=%h intr=%b, want 805 1", rd, intr);
        end
        wb_xfer(1'b0, 4'h2, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'd2) begin
            errors++;
            $display("FAIL frames_after_w1c: got %0d, want 2", rd);
        end
    endtask

    task automatic test_overflow_bad();
        logic [31:0] rd;
        logic        ok;
        int          w[16];
        int          d;
        for (int i = 0; i < 16; i++) w[i] = 120 + 5 * i;
        send_body(w, 10);
        pulse();
        for (int i = 0; i < 8; i++) begin
            wb_xfer(1'b0, 4'(4 + i), 32'd0, rd, ok);
            d = int'(rd[15:0]) - w[i];
            checks++;
            if (d < -1 || d > 1) begin
                errors++;
                $display("FAIL ovf_ch%0d: got %0d, want %0d+-1", i, rd, w[i]);
            end
        end
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h815) begin
            errors++;
            $display("FAIL ovf_status: got %h, want 815", rd);
        end
        w[0] = 100; w[1] = 20; w[2] = 110;
        send_body(w, 3);
        pulse();
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h81D) begin
            errors++;
            $display("FAIL bad_status: got %h, want 81d", rd);
        end
        wb_xfer(1'b0, 4'h2, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'd3) begin
            errors++;
            $display("FAIL bad_frames_count: got %0d, want 3", rd);
        end
        wb_xfer(1'b0, 4'h4, 32'd0, rd, ok);
        d = int'(rd[15:0]) - 120;
        checks++;
        if (d < -1 || d > 1) begin
            errors++;
            $display("FAIL bad_shadow_ch0: got %0d, want 120+-1", rd);
        end
        wb_xfer(1'b1, 4'h0, 32'h18, rd, ok);
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h805) begin
            errors++;
            $display("FAIL bad_ovf_w1c: got %h, want 805", rd);
        end
    endtask

    task automatic test_lost();
        logic [31:0] rd;
        logic        ok;
        int          w[16];
        for (int i = 0; i < 16; i++) w[i] = 100 + 10 * i;
        send_body(w, 8);
        pulse();
        // pulse() ends 14 negedges after the pin edge; sample at ~2499 us and ~2504 us
        repeat (4997 - 14) @(negedge clk);
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h805) begin
            errors++;
            $display("FAIL lost_early: got %h, want 805", rd);
        end
        repeat (5008 - 4999) @(negedge clk);
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h806) begin
            errors++;
            $display("FAIL lost_set: got %h, want 806", rd);
        end
        repeat (6000 - 5010) @(negedge clk);
        send_body(w, 8);
        pulse();
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h805) begin
            errors++;
            $display("FAIL lost_recover: got %h, want 805", rd);
        end
        wb_xfer(1'b0, 4'h2, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'd5) begin
            errors++;
            $display("FAIL lost_frames: got %0d, want 5", rd);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        logic        ok;
        int          w[16];
        int          d;
        idle_us(GAP);
        gap_us(100);
        ppm_in = 1'b1;
        repeat (20) @(negedge clk);
        ppm_in = 1'b0;
        repeat (50) @(negedge clk);
        wb_adr_i = 32'h10;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wb_ack_o !== 1'b1 || wb_dat_o === 32'd0 || intr !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: ack=%b dat=%h intr=%b, want 1 nonzero 1", wb_ack_o, wb_dat_o, intr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'd0 || intr !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ack=%b dat=%h intr=%b, want 0 0 0", wb_ack_o, wb_dat_o, intr);
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wb_xfer(1'b1, 4'h1, 32'h3, rd, ok);
        w[0] = 100; w[1] = 110; w[2] = 120;
        send_body(w, 3);
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rst_first_sync: status=%h, want 0", rd);
        end
        pulse();
        wb_xfer(1'b0, 4'h0, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'h305) begin
            errors++;
            $display("FAIL rst_second_sync: status=%h, want 305", rd);
        end
        wb_xfer(1'b0, 4'h2, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'd1) begin
            errors++;
            $display("FAIL rst_frames: got %0d, want 1", rd);
        end
        for (int i = 0; i < 3; i++) begin
            wb_xfer(1'b0, 4'(4 + i), 32'd0, rd, ok);
            d = int'(rd[15:0]) - w[i];
            checks++;
            if (d < -1 || d > 1) begin
                errors++;
                $display("FAIL rst_ch%0d: got %0d, want %0d+-1", i, rd, w[i]);
            end
        end
        wb_xfer(1'b0, 4'h7, 32'd0, rd, ok);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL rst_live_cleared: ch3=%0d, want 0", rd);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ppm_in   = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = 4'hF;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_frame();
        test_irq_clear();
        test_overflow_bad();
        test_lost();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
